// File: rtl/doff_pkg.sv
// Shared constants for the dump-off routing and select blocks.
package doff_pkg;

   typedef enum logic [1:0] {
      ST_PARK  = 2'd0,
      ST_RUN   = 2'd1,
      ST_GUARD = 2'd2,
      ST_FAULT = 2'd3
   } doff_state_t;

   localparam logic [1:0] SEL_PARK = 2'd3;

endpackage

// File: rtl/doff_guard_cnt.sv
// Loadable down-counter for the break-before-make dead time; done while at zero.
module doff_guard_cnt #(
   parameter int W = 4
) (
   input  logic         clk_sys,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/doff_route.sv
// Routes one dump-off command to one of three channel lines with break-before-make
// guard time on reselect and an on-time watchdog that latches a fault.
//
// state | meaning
// PARK  | nothing routed, all lines low
// RUN   | dumpoffin forwarded to the line selected by sel_cur
// GUARD | dead time after a select change, all lines low, busy high
// FAULT | watchdog tripped, all lines low until fault_clr with dumpoffin low
module doff_route
   import doff_pkg::*;
#(
   parameter int DEAD_CYC = 8,
   parameter int MAX_ON   = 4096,
   parameter int CNT_W    = 13
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic [1:0] change,
   input  logic       dumpoffin,
   input  logic       fault_clr,
   output logic       dumpoff0,
   output logic       dumpoff1,
   output logic       dumpoff2,
   output logic [1:0] sel_cur,
   output logic       busy,
   output logic       fault
);

   localparam int GW = $clog2(DEAD_CYC + 1);
   localparam logic [GW-1:0]    GUARD_LD = GW'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] ON_LIM   = CNT_W'(MAX_ON - 1);

   doff_state_t      state_q, state_d;
   logic [1:0]       target_q, target_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] on_q, on_d;
   logic [2:0]       dout_q, dout_d;
   logic             g_load, g_en, g_done;
   logic             trip;

   doff_guard_cnt #(.W(GW)) u_guard (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .load     (g_load),
      .load_val (GUARD_LD),
      .en       (g_en),
      .done     (g_done)
   );

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q  <= ST_PARK;
         target_q <= SEL_PARK;
         sel_q    <= SEL_PARK;
         on_q     <= '0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         sel_q    <= sel_d;
         on_q     <= on_d;
         dout_q   <= dout_d;
      end
   end

   // Trip on the cycle the line has been high MAX_ON times, so it drops right after.
   assign trip = (|dout_q) && (on_q >= ON_LIM);

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      sel_d    = sel_q;
      g_load   = 1'b0;
      g_en     = 1'b0;
      case (state_q)
         ST_PARK: begin
            if (change != SEL_PARK) begin
               state_d  = ST_GUARD;
               target_d = change;
               g_load   = 1'b1;
            end
         end
         ST_RUN: begin
            if (change != sel_q) begin
               state_d  = ST_GUARD;
               target_d = change;
               g_load   = 1'b1;
            end else if (trip) begin
               state_d = ST_FAULT;
            end
         end
         ST_GUARD: begin
            if (change != target_q) begin
               target_d = change;
               g_load   = 1'b1;
            end else if (g_done) begin
               sel_d   = target_q;
               state_d = (target_q == SEL_PARK) ? ST_PARK : ST_RUN;
            end else begin
               g_en = 1'b1;
            end
         end
         ST_FAULT: begin
            if (fault_clr && !dumpoffin) begin
               state_d  = ST_GUARD;
               target_d = change;
               g_load   = 1'b1;
            end
         end
         default: state_d = ST_PARK;
      endcase
   end

   always_comb begin
      logic fwd;
      fwd    = (state_q == ST_RUN) && (state_d == ST_RUN) && dumpoffin;
      dout_d = {fwd && (sel_q == 2'd2), fwd && (sel_q == 2'd1), fwd && (sel_q == 2'd0)};
      if ((state_d != ST_RUN) || !(|dout_q)) begin
         on_d = '0;
      end else if (on_q != {CNT_W{1'b1}}) begin
         on_d = on_q + 1'b1;
      end else begin
         on_d = on_q;
      end
   end

   always_comb begin
      busy     = (state_q == ST_GUARD);
      fault    = (state_q == ST_FAULT);
      sel_cur  = sel_q;
      dumpoff0 = dout_q[0];
      dumpoff1 = dout_q[1];
      dumpoff2 = dout_q[2];
   end

endmodule

// File: tb/tb_doff_route.sv
// Scenario bench for doff_route: directed switchover/watchdog cases plus a randomized soak
// against a behavioural model.
module tb_doff_route;

   localparam int DEAD   = 8;
   localparam int MAX_ON = 4096;

   logic       clk_sys = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] change = 2'd3;
   logic       dumpoffin = 1'b0;
   logic       fault_clr = 1'b0;
   logic       dumpoff0, dumpoff1, dumpoff2;
   logic [1:0] sel_cur;
   logic       busy, fault;

   int n_checks = 0;
   int n_pass   = 0;

   doff_route #(.DEAD_CYC(DEAD), .MAX_ON(MAX_ON), .CNT_W(13)) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .change    (change),
      .dumpoffin (dumpoffin),
      .fault_clr (fault_clr),
      .dumpoff0  (dumpoff0),
      .dumpoff1  (dumpoff1),
      .dumpoff2  (dumpoff2),
      .sel_cur   (sel_cur),
      .busy      (busy),
      .fault     (fault)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end

   task automatic clk1;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; change = 2'd3; dumpoffin = 1'b0; fault_clr = 1'b0;
      repeat (3) clk1();
      n_checks++;
      if ({dumpoff2, dumpoff1, dumpoff0} !== 3'b000) $display("FAIL reset_dout got %b want 000", {dumpoff2, dumpoff1, dumpoff0});
      else n_pass++;
      n_checks++;
      if (sel_cur !== 2'd3) $display("FAIL reset_sel got %0d want 3", sel_cur);
      else n_pass++;
      n_checks++;
      if ({busy, fault} !== 2'b00) $display("FAIL reset_flags got %b want 00", {busy, fault});
      else n_pass++;
      rst = 1'b0;
      repeat (2) clk1();
      n_checks++;
      if ({busy, fault, sel_cur} !== 4'b0011) $display("FAIL park_idle got %b want 0011", {busy, fault, sel_cur});
      else n_pass++;
   endtask

   task automatic test_route_pulse;
      int busy_n = 0, hi1 = 0, others = 0;
      bit seen = 0;
      change = 2'd1;
      for (int i = 0; i < 30; i++) begin
         clk1();
         if (busy) begin busy_n++; seen = 1; end
         else if (seen) break;
      end
      n_checks++;
      if (busy_n !== DEAD) $display("FAIL route_guard_len got %0d want %0d", busy_n, DEAD);
      else n_pass++;
      n_checks++;
      if (sel_cur !== 2'd1) $display("FAIL route_sel got %0d want 1", sel_cur);
      else n_pass++;
      dumpoffin = 1'b1;
      #1;
      n_checks++;
      if (dumpoff1 !== 1'b0) $display("FAIL route_lag got %b want 0", dumpoff1);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         clk1();
         hi1 += int'(dumpoff1);
         if (dumpoff0 || dumpoff2) others++;
      end
      dumpoffin = 1'b0;
      clk1();
      n_checks++;
      if (dumpoff1 !== 1'b0) $display("FAIL route_deassert got %b want 0", dumpoff1);
      else n_pass++;
      n_checks++;
      if (hi1 !== 5) $display("FAIL route_high_len got %0d want 5", hi1);
      else n_pass++;
      n_checks++;
      if (others !== 0) $display("FAIL route_other_lines got %0d want 0", others);
      else n_pass++;
   endtask

   task automatic test_switch;
      int busy_n = 1, any_hi = 0;
      dumpoffin = 1'b1;
      clk1();
      n_checks++;
      if (dumpoff1 !== 1'b1) $display("FAIL switch_pre got %b want 1", dumpoff1);
      else n_pass++;
      change = 2'd2;
      clk1();
      n_checks++;
      if ({busy, dumpoff2, dumpoff1, dumpoff0} !== 4'b1000) $display("FAIL switch_break got %b want 1000", {busy, dumpoff2, dumpoff1, dumpoff0});
      else n_pass++;
      for (int i = 0; i < 30; i++) begin
         clk1();
         if (!busy) break;
         busy_n++;
         if (dumpoff0 || dumpoff1 || dumpoff2) any_hi++;
      end
      n_checks++;
      if (busy_n !== DEAD) $display("FAIL switch_guard_len got %0d want %0d", busy_n, DEAD);
      else n_pass++;
      n_checks++;
      if (any_hi !== 0) $display("FAIL switch_guard_quiet got %0d want 0", any_hi);
      else n_pass++;
      n_checks++;
      if ({sel_cur, dumpoff2} !== 3'b100) $display("FAIL switch_exit got %b want 100", {sel_cur, dumpoff2});
      else n_pass++;
      clk1();
      n_checks++;
      if ({dumpoff2, dumpoff1, dumpoff0} !== 3'b100) $display("FAIL switch_make got %b want 100", {dumpoff2, dumpoff1, dumpoff0});
      else n_pass++;
      dumpoffin = 1'b0;
      clk1();
   endtask

   task automatic test_glitch;
      int busy_n = 1, any_hi = 0;
      dumpoffin = 1'b1;
      change = 2'd0;
      clk1();
      if (dumpoff0 || dumpoff1 || dumpoff2) any_hi++;
      repeat (3) begin clk1(); if (dumpoff0 || dumpoff1 || dumpoff2) any_hi++; end
      change = 2'd2;
      clk1();
      if (dumpoff0 || dumpoff1 || dumpoff2) any_hi++;
      repeat (2) begin clk1(); if (dumpoff0 || dumpoff1 || dumpoff2) any_hi++; end
      change = 2'd0;
      clk1();
      n_checks++;
      if (busy !== 1'b1) $display("FAIL glitch_busy got %b want 1", busy);
      else n_pass++;
      for (int i = 0; i < 30; i++) begin
         clk1();
         if (!busy) break;
         busy_n++;
         if (dumpoff0 || dumpoff1 || dumpoff2) any_hi++;
      end
      n_checks++;
      if (busy_n !== DEAD) $display("FAIL glitch_restart_len got %0d want %0d", busy_n, DEAD);
      else n_pass++;
      n_checks++;
      if (any_hi !== 0) $display("FAIL glitch_quiet got %0d want 0", any_hi);
      else n_pass++;
      n_checks++;
      if (sel_cur !== 2'd0) $display("FAIL glitch_sel got %0d want 0", sel_cur);
      else n_pass++;
      clk1();
      n_checks++;
      if ({dumpoff2, dumpoff1, dumpoff0} !== 3'b001) $display("FAIL glitch_make got %b want 001", {dumpoff2, dumpoff1, dumpoff0});
      else n_pass++;
      dumpoffin = 1'b0;
      clk1();
   endtask

   task automatic test_watchdog;
      int hi0 = 0, fault_at = -1;
      bit seen = 0;
      dumpoffin = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (i == 4500) fault_clr = 1'b1;
         clk1();
         fault_clr = 1'b0;
         hi0 += int'(dumpoff0);
         if (fault && fault_at < 0) fault_at = i;
      end
      n_checks++;
      if (hi0 !== MAX_ON) $display("FAIL wd_high_len got %0d want %0d", hi0, MAX_ON);
      else n_pass++;
      n_checks++;
      if (fault_at !== MAX_ON) $display("FAIL wd_trip_cycle got %0d want %0d", fault_at, MAX_ON);
      else n_pass++;
      n_checks++;
      if ({fault, busy, dumpoff0} !== 3'b100) $display("FAIL wd_clr_ignored got %b want 100", {fault, busy, dumpoff0});
      else n_pass++;
      dumpoffin = 1'b0;
      clk1();
      n_checks++;
      if (fault !== 1'b1) $display("FAIL wd_sticky got %b want 1", fault);
      else n_pass++;
      fault_clr = 1'b1;
      clk1();
      fault_clr = 1'b0;
      n_checks++;
      if ({fault, busy} !== 2'b01) $display("FAIL wd_clear got %b want 01", {fault, busy});
      else n_pass++;
      for (int i = 0; i < 30; i++) begin
         clk1();
         if (!busy) begin seen = 1; break; end
      end
      n_checks++;
      if (!seen || sel_cur !== 2'd0) $display("FAIL wd_rerun got done=%0d sel=%0d want done=1 sel=0", seen, sel_cur);
      else n_pass++;
      dumpoffin = 1'b1;
      clk1();
      n_checks++;
      if (dumpoff0 !== 1'b1) $display("FAIL wd_resume got %b want 1", dumpoff0);
      else n_pass++;
      dumpoffin = 1'b0;
      clk1();
   endtask

   task automatic test_park;
      int busy_n = 0, any_hi = 0;
      bit seen = 0;
      change = 2'd3;
      for (int i = 0; i < 30; i++) begin
         clk1();
         if (busy) begin busy_n++; seen = 1; end
         else if (seen) break;
      end
      n_checks++;
      if (busy_n !== DEAD || sel_cur !== 2'd3) $display("FAIL park_entry got guard=%0d sel=%0d want guard=%0d sel=3", busy_n, sel_cur, DEAD);
      else n_pass++;
      dumpoffin = 1'b1;
      repeat (5) begin clk1(); if (dumpoff0 || dumpoff1 || dumpoff2 || busy) any_hi++; end
      dumpoffin = 1'b0;
      n_checks++;
      if (any_hi !== 0) $display("FAIL park_silent got %0d want 0", any_hi);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      bit seen = 0;
      change = 2'd2;
      for (int i = 0; i < 30; i++) begin
         clk1();
         if (busy) seen = 1;
         else if (seen) break;
      end
      dumpoffin = 1'b1;
      clk1();
      n_checks++;
      if (dumpoff2 !== 1'b1) $display("FAIL rstmid_pre got %b want 1", dumpoff2);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({dumpoff2, dumpoff1, dumpoff0} !== 3'b000) $display("FAIL rstmid_drop got %b want 000", {dumpoff2, dumpoff1, dumpoff0});
      else n_pass++;
      n_checks++;
      if ({sel_cur, busy, fault} !== 4'b1100) $display("FAIL rstmid_state got %b want 1100", {sel_cur, busy, fault});
      else n_pass++;
      change = 2'd3;
      dumpoffin = 1'b0;
      clk1();
      rst = 1'b0;
      clk1();
      n_checks++;
      if ({dumpoff2, dumpoff1, dumpoff0, busy, sel_cur} !== 6'b000011) $display("FAIL rstmid_park got %b want 000011", {dumpoff2, dumpoff1, dumpoff0, busy, sel_cur});
      else n_pass++;
   endtask

   task automatic test_soak;
      int m_sel = 3, m_tgt = 3, m_left = 0, m_high = 0;
      bit m_fault = 0;
      logic [2:0] m_out = 3'b000, next_out;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) change = 2'($urandom_range(0, 3));
         dumpoffin = ($urandom_range(0, 2) != 0);
         fault_clr = ($urandom_range(0, 15) == 0);
         next_out = 3'b000;
         if (m_fault) begin
            if (fault_clr && !dumpoffin) begin m_fault = 0; m_tgt = int'(change); m_left = DEAD; end
         end else if (m_left > 0) begin
            if (int'(change) != m_tgt) begin m_tgt = int'(change); m_left = DEAD; end
            else begin m_left--; if (m_left == 0) m_sel = m_tgt; end
         end else if (int'(change) != m_sel) begin
            m_tgt = int'(change); m_left = DEAD;
         end else if (m_sel != 3) begin
            if (m_out != 3'b000 && m_high == MAX_ON) m_fault = 1;
            else if (dumpoffin) next_out = 3'(1 << m_sel);
         end
         m_high = (next_out != 3'b000) ? m_high + 1 : 0;
         m_out = next_out;
         clk1();
         n_checks++;
         if ({dumpoff2, dumpoff1, dumpoff0} !== m_out || sel_cur !== 2'(m_sel) || busy !== (m_left > 0) || fault !== m_fault)
            $display("FAIL soak_cycle%0d got dout=%b sel=%0d busy=%b fault=%b want dout=%b sel=%0d busy=%b fault=%b",
                     c, {dumpoff2, dumpoff1, dumpoff0}, sel_cur, busy, fault, m_out, m_sel, (m_left > 0), m_fault);
         else n_pass++;
         n_checks++;
         if ($countones({dumpoff2, dumpoff1, dumpoff0}) > 1) $display("FAIL soak_onehot%0d got %b want at most one high", c, {dumpoff2, dumpoff1, dumpoff0});
         else n_pass++;
      end
      fault_clr = 1'b0;
      dumpoffin = 1'b0;
   endtask

   initial begin
      test_reset();
      test_route_pulse();
      test_switch();
      test_glitch();
      test_watchdog();
      test_park();
      test_reset_mid();
      test_soak();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
